// File: rtl/mac_rr_scheduler_if.sv
// mac_rr_scheduler_if: requester, response and MAC-side signals of the
// round-robin MAC scheduler; the scheduler takes the slave modport.
interface mac_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 16
);
    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [NUM_REQ-1:0]        REQ_READY;
    logic [NUM_REQ*DATA_W-1:0] REQ_A;
    logic [NUM_REQ*DATA_W-1:0] REQ_B;
    logic [NUM_REQ*DATA_W-1:0] REQ_C;
    logic [NUM_REQ-1:0]        RSP_VALID;
    logic [NUM_REQ-1:0]        RSP_READY;
    logic [OUT_W-1:0]          RSP_DATA;
    logic                      RSP_ERR;
    logic                      MAC_EN;
    logic [DATA_W-1:0]         MAC_A;
    logic [DATA_W-1:0]         MAC_B;
    logic [DATA_W-1:0]         MAC_C;
    logic                      MAC_DONE;
    logic [OUT_W-1:0]          MAC_MOUT;
    logic                      BUSY;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, REQ_C, RSP_READY,
        output MAC_DONE, MAC_MOUT,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        input  MAC_EN, MAC_A, MAC_B, MAC_C, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, REQ_C, RSP_READY,
        input  MAC_DONE, MAC_MOUT,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        output MAC_EN, MAC_A, MAC_B, MAC_C, BUSY
    );
endinterface

// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler: round-robin sharing of one MAC among NUM_REQ requesters.
// Define MAC_SCHED_TIMEOUT_EN to enable the ISSUE watchdog abort.
module mac_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int OUT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic CLK,
    input logic RSTn,
    mac_rr_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  c_q, c_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               en_q, en_d;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               tmo;
    logic               rsp_hs;

    function automatic logic [IDX_W-1:0] nxt_idx(
        input logic [IDX_W-1:0] i,
        input int               k
    );
        int s;
        s = int'(i) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Walk from the farthest offset down so the nearest VALID at/after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.REQ_VALID[nxt_idx(ptr_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = nxt_idx(ptr_q, k);
            end
        end
    end

    assign rsp_hs = (state_q == RESP) && bus.RSP_READY[g_q];

`ifdef MAC_SCHED_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    assign tmo = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ISSUE && !bus.MAC_DONE) cnt_d = cnt_q + 8'd1;
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ISSUE && !bus.MAC_DONE && tmo) err_d = 1'b1;
        if (rsp_hs) err_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.RSP_ERR = err_q;
`else
    assign tmo         = 1'b0;
    assign bus.RSP_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_vld) state_d = ISSUE;
            ISSUE:   if (bus.MAC_DONE || tmo) state_d = RESP;
            RESP:    if (rsp_hs) state_d = bus.MAC_DONE ? DRAIN : IDLE;
            DRAIN:   if (!bus.MAC_DONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        unique case (1'b1)
            (state_q == IDLE): if (pick_vld) req_ready[pick_idx] = 1'b1;
            (state_q == RESP): rsp_valid[g_q] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        g_d    = g_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        data_d = data_q;
        en_d   = en_q;
        if (state_q == IDLE && pick_vld) begin
            g_d   = pick_idx;
            ptr_d = nxt_idx(pick_idx, 1);
            en_d  = 1'b1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pick_idx == IDX_W'(k)) begin
                    a_d = bus.REQ_A[k*DATA_W +: DATA_W];
                    b_d = bus.REQ_B[k*DATA_W +: DATA_W];
                    c_d = bus.REQ_C[k*DATA_W +: DATA_W];
                end
            end
        end
        if (state_q == ISSUE) begin
            if (bus.MAC_DONE) begin
                data_d = bus.MAC_MOUT;
                en_d   = 1'b0;
            end else if (tmo) begin
                data_d = '0;
                en_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q  <= '0;
            g_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            g_q    <= g_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    assign bus.REQ_READY = req_ready;
    assign bus.RSP_VALID = rsp_valid;
    assign bus.RSP_DATA  = data_q;
    assign bus.MAC_EN    = en_q;
    assign bus.MAC_A     = a_q;
    assign bus.MAC_B     = b_q;
    assign bus.MAC_C     = c_q;
    assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb_mac_rr_scheduler: random requesters and a behavioural MAC, checked
// cycle by cycle against a transaction-level round-robin model.
module tb_mac_rr_scheduler;
    localparam int N = 4;
`ifdef MAC_SCHED_TIMEOUT_EN
    localparam int TMO    = 8;
    localparam bit TMO_ON = 1'b1;
`else
    localparam int TMO    = 64;
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mac_rr_scheduler_if #(.NUM_REQ(N), .DATA_W(8), .OUT_W(16)) bus ();

    mac_rr_scheduler #(
        .NUM_REQ(N), .DATA_W(8), .OUT_W(16), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK (clk),
        .RSTn(rstn),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mac_ref(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] c);
        return {8'd0, a} * {8'd0, b} + {8'd0, c};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // MAC: DONE rises on the third edge with EN seen, stays up two cycles.
    logic       mac_dead = 1'b0;
    logic [1:0] ecnt;
    logic       fired, hold;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ecnt <= 0; fired <= 0; hold <= 0;
            bus.MAC_DONE <= 0; bus.MAC_MOUT <= 0;
        end else if (!bus.MAC_EN) begin
            ecnt <= 0; fired <= 0;
            if (bus.MAC_DONE) begin
                if (hold) hold <= 0;
                else bus.MAC_DONE <= 0;
            end
        end else if (!fired && !mac_dead) begin
            if (ecnt == 2) begin
                bus.MAC_DONE <= 1; hold <= 1; fired <= 1;
                bus.MAC_MOUT <= mac_ref(bus.MAC_A, bus.MAC_B, bus.MAC_C);
            end else ecnt <= ecnt + 1;
        end else if (bus.MAC_DONE) begin
            if (hold) hold <= 0;
            else bus.MAC_DONE <= 0;
        end
    end

    // Model: 0 idle, 1 awaiting MAC, 2 response offered, 3 waiting DONE low.
    int         m_ph, m_ptr, m_g, m_cnt;
    logic [7:0] m_a, m_b, m_c;
    logic [15:0] m_data;
    logic       m_err;
    logic [N-1:0] pend;
    int         aborts = 0;

    task automatic drive_idle();
        bus.REQ_VALID = '0;
        bus.REQ_A = '0; bus.REQ_B = '0; bus.REQ_C = '0;
        bus.RSP_READY = '0;
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        rstn = 1'b0;
        #1;
        chk({tag, "_en"},    32'(bus.MAC_EN), 0);
        chk({tag, "_rspv"},  32'(bus.RSP_VALID), 0);
        chk({tag, "_busy"},  32'(bus.BUSY), 0);
        chk({tag, "_rdy"},   32'(bus.REQ_READY), 0);
        chk({tag, "_err"},   32'(bus.RSP_ERR), 0);
        chk({tag, "_data"},  32'(bus.RSP_DATA), 0);
        chk({tag, "_ops"},   32'({bus.MAC_A, bus.MAC_B, bus.MAC_C}), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        m_ph = 0; m_ptr = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic check_cycle();
        logic [N-1:0] er;
        int p;
        er = '0;
        p  = rr_pick(bus.REQ_VALID, m_ptr);
        if (m_ph == 0 && p >= 0) er[p] = 1'b1;
        chk("req_ready", 32'(bus.REQ_READY), 32'(er));
        chk("rsp_valid", 32'(bus.RSP_VALID),
            (m_ph == 2) ? (32'd1 << m_g) : 32'd0);
        chk("busy",   32'(bus.BUSY), 32'(m_ph != 0));
        chk("mac_en", 32'(bus.MAC_EN), 32'(m_ph == 1));
        chk("rsp_err", 32'(bus.RSP_ERR), 32'(m_err));
        if (m_ph == 2) chk("rsp_data", 32'(bus.RSP_DATA), 32'(m_data));
        if (m_ph == 1)
            chk("mac_ops", 32'({bus.MAC_A, bus.MAC_B, bus.MAC_C}),
                32'({m_a, m_b, m_c}));
        // Advance the model to the state it must hold after the next edge.
        if (m_ph == 0) begin
            if (p >= 0) begin
                m_g = p;
                m_a = bus.REQ_A[p*8 +: 8];
                m_b = bus.REQ_B[p*8 +: 8];
                m_c = bus.REQ_C[p*8 +: 8];
                m_ptr = (p + 1) % N;
                pend[p] = 1'b0;
                m_cnt = 0;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            if (bus.MAC_DONE) begin
                m_data = mac_ref(m_a, m_b, m_c);
                m_ph = 2;
            end else if (TMO_ON && m_cnt == TMO - 1) begin
                m_data = '0; m_err = 1'b1; m_ph = 2; aborts++;
            end else m_cnt++;
        end else if (m_ph == 2) begin
            if (bus.RSP_READY[m_g]) begin
                m_err = 1'b0;
                m_ph = bus.MAC_DONE ? 3 : 0;
            end
        end else begin
            if (!bus.MAC_DONE) m_ph = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        pend = '0;
        drive_idle();
        #12;
        do_reset("rst");

        // Single request from requester 0.
        @(posedge clk); #1;
        bus.REQ_VALID = 4'b0001;
        bus.REQ_A[7:0] = 8'h40;
        bus.REQ_B[7:0] = 8'h20;
        bus.REQ_C[7:0] = 8'h10;
        @(negedge clk);
        chk("t1_ready", 32'(bus.REQ_READY), 32'h1);
        chk("t1_en_pre", 32'(bus.MAC_EN), 0);
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        bus.REQ_A = '1;
        chk("t1_en", 32'(bus.MAC_EN), 1);
        chk("t1_ops", 32'({bus.MAC_A, bus.MAC_B, bus.MAC_C}), 32'h402010);
        chk("t1_busy", 32'(bus.BUSY), 1);
        w = 0;
        while (bus.RSP_VALID == 0 && w < 30) begin
            @(negedge clk); w++;
        end
        chk("t1_rsp_wait", 32'(w < 30), 1);
        chk("t1_rspv", 32'(bus.RSP_VALID), 32'h1);
        chk("t1_data", 32'(bus.RSP_DATA), 32'(mac_ref(8'h40, 8'h20, 8'h10)));
        bus.RSP_READY = 4'b0001;
        w = 0;
        while (bus.BUSY && w < 30) begin
            @(negedge clk); w++;
        end
        chk("t1_idle", 32'(bus.BUSY), 0);
        bus.RSP_READY = '0;
        m_ph = 0; m_ptr = 1; m_err = 0;

        // Random traffic against the model, with two mid-ISSUE resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if ((cyc == 900 || cyc == 2000) && m_ph == 1) begin
                do_reset("rst_mid");
            end else if ((cyc == 901 || cyc == 2001) && m_ph == 1) begin
                do_reset("rst_mid");
            end
            if (TMO_ON && $urandom_range(0, 29) == 0) mac_dead = ~mac_dead;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
            end
            bus.REQ_VALID = pend;
            bus.REQ_A = $urandom;
            bus.REQ_B = $urandom;
            bus.REQ_C = $urandom;
            for (int i = 0; i < N; i++)
                bus.RSP_READY[i] = ($urandom_range(0, 9) < 4);
            @(negedge clk);
            check_cycle();
        end

        if (TMO_ON) chk("aborts_seen", 32'(aborts > 0), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
